// File: rtl/uart_pkg.sv
// Shared UART definitions: default line rate, frame width and the receiver/transmitter state encoding.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 5208;
    localparam int DATA_BITS_DEFAULT    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input; both flops reset to 1.
module uart_sync (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver (LSB first, idle-high) with a one-entry holding register and valid/read handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_next;
    logic                 rx_s;
    logic                 rx_prev;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift;
    logic                 load;
    logic                 stop_bad;

    uart_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only a 1->0 transition of the synchronised line starts a frame, so a held break is ignored.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE:  if (rx_prev && !rx_s) state_next = START;
            START: if (cnt == CNT_HALF) state_next = rx_s ? IDLE : DATA;
            DATA:  if (cnt == CNT_LAST && idx == IDX_LAST) state_next = STOP;
            STOP: begin
                if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    load       = rx_s;
                    stop_bad   = !rx_s;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_prev <= 1'b1;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
        end else begin
            rx_prev <= rx_s;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                end
                START: cnt <= (cnt == CNT_HALF) ? '0 : cnt + 1'b1;
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        idx        <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

    // A read in the same cycle as a load hands the slot straight to the new byte without overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data      <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (load) begin
                if (!valid) begin
                    data  <= shift;
                    valid <= 1'b1;
                end else if (rd) begin
                    data <= shift;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rd && valid) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule
